// File: rtl/traffic_master_if.sv
// Four-phase req/ack bus between the traffic master and a memory slave.
`timescale 1ns/1ps
interface traffic_master_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  // Handshake: master raises req with cmd/addr/wdata stable; slave raises ack
  // (rdata valid while ack=1 on a read); master drops req; slave drops ack.
  // req only rises again once ack has been seen low.
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, cmd, addr, wdata, input ack, rdata);
  modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/traffic_master.sv
// Bus traffic generator: stepped write/read-back pairs over the four-phase bus.
// Define TRAFFIC_MASTER_CHECK_EN to enable read-back compare and err_cnt.
`timescale 1ns/1ps
module traffic_master #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_PAIRS = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [63:0] ADDR_STEP = 64'hCE2,
  parameter int unsigned N         = 0,
  parameter logic [63:0] DATA_SEED = 64'h0,
  parameter logic [63:0] DATA_STEP = 64'h345,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  traffic_master_if.master bus,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [15:0]      err_cnt,
  output logic [2:0]       dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP >> N);
  localparam logic [DATA_W-1:0] DATA_BASE = DATA_W'(DATA_SEED);
  localparam logic [DATA_W-1:0] DATA_INC  = DATA_W'(DATA_STEP);
  localparam logic [16:0]       LAST_K    = 17'(2 * NUM_PAIRS - 1);
  localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_NACK = 3'd2,
    S_NEXT      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [16:0]       k_q, k_d;
  logic [ADDR_W-1:0] addr_acc_q, addr_acc_d;
  logic [DATA_W-1:0] data_acc_q, data_acc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    addr_acc_d = addr_acc_q;
    data_acc_d = data_acc_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          k_d        = '0;
          addr_acc_d = ADDR_BASE;
          data_acc_d = DATA_BASE;
          cnt_d      = '0;
          req_d      = 1'b1;
          cmd_d      = 1'b1;
          addr_d     = ADDR_BASE;
          wdata_d    = DATA_BASE;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_NACK;
        end else if (cnt_q == TO_LAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_NACK: begin
        if (!bus.ack) begin
          state_d = S_NEXT;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_NEXT: begin
        if (k_q == LAST_K) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 17'd1;
          // The accumulators advance only after the read half of a pair.
          if (k_q[0]) begin
            addr_acc_d = addr_acc_q + ADDR_INC;
            data_acc_d = data_acc_q + DATA_INC;
          end
          cmd_d   = k_q[0];
          addr_d  = addr_acc_d;
          wdata_d = k_q[0] ? data_acc_d : '0;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_REQ) || (state_d == S_WAIT_NACK) || (state_d == S_NEXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      addr_acc_q <= '0;
      data_acc_q <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      addr_acc_q <= addr_acc_d;
      data_acc_q <= data_acc_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef TRAFFIC_MASTER_CHECK_EN
  logic [15:0] err_q, err_d;

  // rdata is captured on the same edge that sees ack high during a read.
  always_comb begin
    err_d = err_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      err_d = '0;
    end else if ((state_q == S_REQ) && bus.ack && !cmd_q &&
                 (bus.rdata != data_acc_q) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.rdata;
  assign err_cnt      = 16'h0;
`endif

  assign bus.req   = req_q;
  assign bus.cmd   = cmd_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
